// File: rtl/cla_nibble_sequencer_if.sv
// Operand/result handshake and CLA slice hookup for cla_nibble_sequencer.
// The slave modport is the sequencer side; the master modport is the requester/consumer/slice side.
interface cla_nibble_sequencer_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [3:0]       cla_a;
  logic [3:0]       cla_b;
  logic             cla_cin;
  logic [3:0]       cla_sum;
  logic             cla_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, cla_sum, cla_carry, out_ready,
    output in_ready, cla_a, cla_b, cla_cin, out_valid, out_sum, out_carry
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, cla_sum, cla_carry, out_ready,
    input  in_ready, cla_a, cla_b, cla_cin, out_valid, out_sum, out_carry
  );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Serialises a WIDTH-bit add through an external 4-bit CLA slice, one nibble per cycle LSB first,
// rippling the slice carry through a register and presenting {carry,sum} over valid/ready.
module cla_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  cla_nibble_sequencer_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("cla_nibble_sequencer: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [NIB-1:0][3:0] nib_vec_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  nib_vec_t      a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          carry_q, carry_d, cout_q, cout_d;
  logic [3:0]    cla_a_c, cla_b_c;
  logic          cla_cin_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    cla_a_c   = 4'h0;
    cla_b_c   = 4'h0;
    cla_cin_c = 1'b0;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d     = bus.in_a;
        b_d     = bus.in_b;
        carry_d = bus.in_cin;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cla_a_c        = a_q[idx_q];
        cla_b_c        = b_q[idx_q];
        cla_cin_c      = carry_q;
        sum_d[idx_q]   = bus.cla_sum;
        carry_d        = bus.cla_carry;
        idx_d          = idx_q + 1'b1;
        // last nibble: its slice carry is the carry-out of the whole word
        if (idx_q == IW'(NIB - 1)) begin
          cout_d  = bus.cla_carry;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_carry = cout_q;
  assign bus.cla_a     = cla_a_c;
  assign bus.cla_b     = cla_b_c;
  assign bus.cla_cin   = cla_cin_c;
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer at WIDTH=16 and WIDTH=4, each with a behavioural 4-bit slice.
module tb_cla_nibble_sequencer;
  logic clk;
  logic rst_n;
  int   npass;
  int   ntot;

  cla_nibble_sequencer_if #(.WIDTH(16)) b16();
  cla_nibble_sequencer_if #(.WIDTH(4))  b4();

  cla_nibble_sequencer #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
  cla_nibble_sequencer #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  assign {b16.cla_carry, b16.cla_sum} = {1'b0, b16.cla_a} + {1'b0, b16.cla_b} + {4'b0, b16.cla_cin};
  assign {b4.cla_carry,  b4.cla_sum}  = {1'b0, b4.cla_a}  + {1'b0, b4.cla_b}  + {4'b0, b4.cla_cin};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one WIDTH=16 op; returns observed result, accept-to-valid latency, in_ready-low flag
  // and the cla_cin seen in each RUN cycle. hold = extra DONE cycles before out_ready.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin, input int hold,
                       output logic [15:0] s, output logic c, output int lat,
                       output bit rdy_low, output logic [3:0] cins);
    int n;
    b16.in_a = a; b16.in_b = b; b16.in_cin = cin; b16.in_valid = 1'b1; b16.out_ready = 1'b0;
    n = 0;
    while (!b16.in_ready && n < 20) begin tick(); n++; end
    tick();
    b16.in_valid = 1'b0; b16.in_a = 16'($urandom); b16.in_b = 16'($urandom);
    lat = 0; rdy_low = 1'b1; cins = 4'h0;
    while (!b16.out_valid && lat < 20) begin
      if (lat < 4) cins[lat] = b16.cla_cin;
      if (b16.in_ready) rdy_low = 1'b0;
      tick(); lat++;
    end
    s = b16.out_sum; c = b16.out_carry;
    repeat (hold) tick();
    b16.out_ready = 1'b1; tick(); b16.out_ready = 1'b0;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin, input int hold,
                      output logic [3:0] s, output logic c, output int lat);
    int n;
    b4.in_a = a; b4.in_b = b; b4.in_cin = cin; b4.in_valid = 1'b1; b4.out_ready = 1'b0;
    n = 0;
    while (!b4.in_ready && n < 20) begin tick(); n++; end
    tick();
    b4.in_valid = 1'b0;
    lat = 0;
    while (!b4.out_valid && lat < 20) begin tick(); lat++; end
    s = b4.out_sum; c = b4.out_carry;
    repeat (hold) tick();
    b4.out_ready = 1'b1; tick(); b4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    ntot++; if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0) $display("FAIL reset16_hs rdy=%b vld=%b want 1/0", b16.in_ready, b16.out_valid); else npass++;
    ntot++; if ({b16.out_carry, b16.out_sum} !== 17'h0) $display("FAIL reset16_out got %h want 0", {b16.out_carry, b16.out_sum}); else npass++;
    ntot++; if ({b16.cla_a, b16.cla_b, b16.cla_cin} !== 9'h0) $display("FAIL reset16_cla got %h want 0", {b16.cla_a, b16.cla_b, b16.cla_cin}); else npass++;
    ntot++; if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0 || {b4.out_carry, b4.out_sum} !== 5'h0)
      $display("FAIL reset4 rdy=%b vld=%b out=%h want 1/0/0", b4.in_ready, b4.out_valid, {b4.out_carry, b4.out_sum}); else npass++;
  endtask

  task automatic test_basic();
    logic [15:0] s; logic c; int lat; bit rl; logic [3:0] ci;
    run16(16'h1234, 16'h4321, 1'b0, 0, s, c, lat, rl, ci);
    ntot++; if ({c, s} !== 17'h05555) $display("FAIL basic_sum got %h want 05555", {c, s}); else npass++;
    ntot++; if (lat !== 4) $display("FAIL basic_latency got %0d want 4", lat); else npass++;
    ntot++; if (rl !== 1'b1) $display("FAIL basic_in_ready got high-in-run want low"); else npass++;
    ntot++; if (ci !== 4'b0000) $display("FAIL basic_cins got %b want 0000", ci); else npass++;
  endtask

  task automatic test_wrap();
    logic [15:0] s; logic c; int lat; bit rl; logic [3:0] ci;
    run16(16'hFFFF, 16'h0001, 1'b0, 0, s, c, lat, rl, ci);
    ntot++; if ({c, s} !== 17'h10000) $display("FAIL wrap_b1 got %h want 10000", {c, s}); else npass++;
    ntot++; if (ci !== 4'b1110) $display("FAIL wrap_cins got %b want 1110 (idx3..0)", ci); else npass++;
    run16(16'hFFFF, 16'h0000, 1'b1, 0, s, c, lat, rl, ci);
    ntot++; if ({c, s} !== 17'h10000) $display("FAIL wrap_cin got %h want 10000", {c, s}); else npass++;
    ntot++; if (ci !== 4'b1111) $display("FAIL wrap_cin_cins got %b want 1111", ci); else npass++;
    run16(16'h0000, 16'h0000, 1'b0, 0, s, c, lat, rl, ci);
    ntot++; if ({c, s} !== 17'h00000) $display("FAIL zero got %h want 00000", {c, s}); else npass++;
  endtask

  task automatic test_backpressure();
    int n;
    b16.in_a = 16'h0F0F; b16.in_b = 16'h1111; b16.in_cin = 1'b1; b16.in_valid = 1'b1; b16.out_ready = 1'b0;
    tick();
    b16.in_valid = 1'b0;
    n = 0;
    while (!b16.out_valid && n < 20) begin tick(); n++; end
    ntot++; if (n !== 4) $display("FAIL bp_latency got %0d want 4", n); else npass++;
    b16.in_a = 16'hAAAA; b16.in_b = 16'h5555; b16.in_cin = 1'b0; b16.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      ntot++;
      if (b16.out_valid !== 1'b1 || b16.in_ready !== 1'b0 || {b16.out_carry, b16.out_sum} !== 17'h02021)
        $display("FAIL bp_hold%0d vld=%b rdy=%b out=%h want 1/0/02021", k, b16.out_valid, b16.in_ready, {b16.out_carry, b16.out_sum});
      else npass++;
    end
    b16.in_valid = 1'b0; b16.out_ready = 1'b1;
    tick();
    b16.out_ready = 1'b0;
    ntot++; if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0) $display("FAIL bp_release rdy=%b vld=%b want 1/0", b16.in_ready, b16.out_valid); else npass++;
    tick();
    ntot++; if (b16.out_valid !== 1'b0 || {b16.out_carry, b16.out_sum} !== 17'h02021)
      $display("FAIL bp_idle_keep vld=%b out=%h want 0/02021", b16.out_valid, {b16.out_carry, b16.out_sum}); else npass++;
  endtask

  task automatic test_async_reset();
    logic [15:0] s; logic c; int lat; bit rl; logic [3:0] ci;
    b16.in_a = 16'hABCD; b16.in_b = 16'h1357; b16.in_cin = 1'b0; b16.in_valid = 1'b1;
    tick();
    b16.in_valid = 1'b0;
    tick(); tick();
    ntot++; if (b16.cla_a !== 4'hB || b16.cla_b !== 4'h3) $display("FAIL ar_idx2 cla_a=%h cla_b=%h want b/3", b16.cla_a, b16.cla_b); else npass++;
    #2 rst_n = 1'b0;
    #1;
    ntot++; if ({b16.out_carry, b16.out_sum} !== 17'h0 || b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1)
      $display("FAIL ar_async out=%h vld=%b rdy=%b want 0/0/1", {b16.out_carry, b16.out_sum}, b16.out_valid, b16.in_ready); else npass++;
    ntot++; if ({b16.cla_a, b16.cla_b, b16.cla_cin} !== 9'h0) $display("FAIL ar_cla got %h want 0", {b16.cla_a, b16.cla_b, b16.cla_cin}); else npass++;
    tick();
    rst_n = 1'b1;
    tick();
    ntot++; if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0) $display("FAIL ar_release rdy=%b vld=%b want 1/0", b16.in_ready, b16.out_valid); else npass++;
    run16(16'h00FF, 16'h0001, 1'b0, 0, s, c, lat, rl, ci);
    ntot++; if ({c, s} !== 17'h00100 || lat !== 4) $display("FAIL ar_next got %h lat %0d want 00100 lat 4", {c, s}, lat); else npass++;
  endtask

  task automatic test_random16(input int nops);
    logic [15:0] a, b, s; logic cin, c; int lat; bit rl; logic [3:0] ci; logic [16:0] exp;
    for (int i = 0; i < nops; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + 17'(cin);
      run16(a, b, cin, $urandom_range(0, 3), s, c, lat, rl, ci);
      ntot++;
      if ({c, s} !== exp || lat !== 4 || rl !== 1'b1)
        $display("FAIL rand16_%0d %h+%h+%b got %h lat %0d rl %b want %h lat 4 rl 1", i, a, b, cin, {c, s}, lat, rl, exp);
      else npass++;
    end
  endtask

  task automatic test_random4(input int nops);
    logic [3:0] a, b, s; logic cin, c; int lat; logic [4:0] exp;
    for (int i = 0; i < nops; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + 5'(cin);
      run4(a, b, cin, $urandom_range(0, 3), s, c, lat);
      ntot++;
      if ({c, s} !== exp || lat !== 1)
        $display("FAIL rand4_%0d %h+%h+%b got %h lat %0d want %h lat 1", i, a, b, cin, {c, s}, lat, exp);
      else npass++;
    end
  endtask

  initial begin
    npass = 0; ntot = 0;
    rst_n = 1'b0;
    b16.in_valid = 1'b0; b16.in_a = '0; b16.in_b = '0; b16.in_cin = 1'b0; b16.out_ready = 1'b0;
    b4.in_valid  = 1'b0; b4.in_a  = '0; b4.in_b  = '0; b4.in_cin  = 1'b0; b4.out_ready  = 1'b0;
    tick(); tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_wrap();
    test_backpressure();
    test_async_reset();
    test_random16(500);
    test_random4(500);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
